// File: rtl/complex_nr_mult_driver_if.sv
// Handshake bundle between the complex multiplier driver and its neighbours.
// master = driver side, slave = upstream source / multiplier / consumer side.
interface complex_nr_mult_driver_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int W = 4 * DATA_WIDTH;

    logic         in_val;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         op_val;
    logic         op_ready;
    logic [W-1:0] op_data;
    logic         res_ready;
    logic         res_val;
    logic [W-1:0] res_data;
    logic         out_val;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        input  in_val, in_data,
        output in_ready,
        output op_val, op_data,
        input  op_ready,
        output res_ready,
        input  res_val, res_data,
        output out_val, out_data,
        input  out_ready
    );

    modport slave (
        output in_val, in_data,
        input  in_ready,
        input  op_val, op_data,
        output op_ready,
        input  res_ready,
        output res_val, res_data,
        input  out_val, out_data,
        output out_ready
    );
endinterface

// File: rtl/complex_nr_mult_driver.sv
// Initiator for the complex multiplier: operand FIFO, one outstanding op, result hand-off.
// Optional WAIT_RES watchdog enabled by defining CMPLX_DRV_TIMEOUT_EN.
module complex_nr_mult_driver #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sw_rst,
    complex_nr_mult_driver_if.master      bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_timeout
);
    localparam int W  = 4 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("complex_nr_mult_driver: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          op_val_q, op_val_d;
    logic [W-1:0]  op_data_q, op_data_d;
    logic          res_ready_q, res_ready_d;
    logic          out_val_q, out_val_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          in_ready;
    logic          push;
    logic          pop;

`ifdef CMPLX_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
`endif

    // Full blocks a push even when a pop lands in the same cycle.
    assign in_ready = (count_q != CW'(FIFO_DEPTH));
    assign push     = bus.in_val & in_ready & ~sw_rst;
    assign pop      = op_val_q & bus.op_ready & ~sw_rst;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        op_val_d    = op_val_q;
        op_data_d   = op_data_q;
        res_ready_d = res_ready_q;
        out_val_d   = out_val_q;
        out_data_d  = out_data_q;
`ifdef CMPLX_DRV_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d   = ISSUE;
                    op_val_d  = 1'b1;
                    op_data_d = mem[rd_ptr_q];
                end
            end
            ISSUE: begin
                if (bus.op_ready) begin
                    state_d     = WAIT_RES;
                    op_val_d    = 1'b0;
                    res_ready_d = 1'b1;
`ifdef CMPLX_DRV_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            WAIT_RES: begin
                // A result arriving on the last allowed cycle beats the watchdog.
                if (bus.res_val) begin
                    state_d     = DRAIN;
                    res_ready_d = 1'b0;
                    out_val_d   = 1'b1;
                    out_data_d  = bus.res_data;
                end
`ifdef CMPLX_DRV_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    res_ready_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    state_d   = IDLE;
                    out_val_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sw_rst) begin
            state_d     = IDLE;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            op_val_d    = 1'b0;
            op_data_d   = '0;
            res_ready_d = 1'b0;
            out_val_d   = 1'b0;
            out_data_d  = '0;
`ifdef CMPLX_DRV_TIMEOUT_EN
            tmo_cnt_d   = '0;
            err_d       = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            op_val_q    <= 1'b0;
            op_data_q   <= '0;
            res_ready_q <= 1'b0;
            out_val_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            op_val_q    <= op_val_d;
            op_data_q   <= op_data_d;
            res_ready_q <= res_ready_d;
            out_val_q   <= out_val_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef CMPLX_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.op_val    = op_val_q;
    assign bus.op_data   = op_data_q;
    assign bus.res_ready = res_ready_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_data  = out_data_q;
    assign fifo_count    = count_q;
endmodule

// File: tb/tb_complex_nr_mult_driver.sv
// Scoreboard bench for complex_nr_mult_driver (DATA_WIDTH=8, FIFO_DEPTH=4).
// Multiplier model computes the signed complex product of each issued word.
module tb_complex_nr_mult_driver;
    logic       clk = 1'b0;
    logic       rstn;
    logic       sw_rst;
    logic [2:0] fifo_count;
    logic       err_timeout;

    complex_nr_mult_driver_if #(.DATA_WIDTH(8)) bus ();

    complex_nr_mult_driver #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sw_rst(sw_rst),
        .bus(bus),
        .fifo_count(fifo_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_op = 0;
    int          n_out = 0;
    int          n_outv = 0;
    int          op_cyc = 0;
    int          out_cyc = 0;
    logic        prev_outv = 1'b0;
    logic [31:0] last_op = '0;
    logic [31:0] last_out = '0;
    logic [31:0] exp_op[$];
    logic [31:0] exp_res[$];

    logic        op_rdy_en = 1'b0;
    logic        mul_resp = 1'b1;
    logic        mul_busy = 1'b0;
    int          mul_wait = 0;
    int          mul_lat = 1;
    logic [31:0] mul_res = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] cmul(input logic [31:0] w);
        logic signed [7:0]  ar, ai, br, bi;
        logic signed [15:0] re, im;
        {ar, ai, br, bi} = w;
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
        return {re, im};
    endfunction

    task automatic monitor();
        logic [31:0] e;
        if (bus.in_val && bus.in_ready && !sw_rst) begin
            exp_op.push_back(bus.in_data);
            exp_res.push_back(cmul(bus.in_data));
        end
        if (bus.op_val && bus.op_ready) begin
            e = (exp_op.size() > 0) ? exp_op.pop_front() : 'x;
            chk("op_order", bus.op_data, e);
            n_op++;
            op_cyc   = cyc;
            last_op  = bus.op_data;
            mul_busy = 1'b1;
            mul_wait = mul_lat;
            mul_res  = cmul(bus.op_data);
        end
        if (bus.res_val && bus.res_ready) begin
            mul_busy = 1'b0;
        end
        if (bus.out_val) begin
            n_outv++;
            if (!prev_outv) out_cyc = cyc;
            if (bus.out_ready) begin
                e = (exp_res.size() > 0) ? exp_res.pop_front() : 'x;
                chk("out_order", bus.out_data, e);
                n_out++;
                last_out = bus.out_data;
            end
        end
        prev_outv = bus.out_val;
    endtask

    task automatic drive_mul();
        bus.op_ready = op_rdy_en;
        bus.res_val  = 1'b0;
        if (mul_busy && mul_resp) begin
            if (mul_wait == 0) begin
                bus.res_val  = 1'b1;
                bus.res_data = mul_res;
            end else begin
                mul_wait--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive_mul();
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.in_val  = 1'b1;
        bus.in_data = d;
        for (int i = 0; i < 50 && !bus.in_ready; i++) step();
        chk("push_ready", bus.in_ready, 1'b1);
        step();
        bus.in_val = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_res.size() != 0; i++) step();
        step();
        chk(tag, exp_res.size(), 0);
    endtask

    int          n0;
    int          v0;
    logic [31:0] seq;

    initial begin
        rstn         = 1'b0;
        sw_rst       = 1'b0;
        bus.in_val   = 1'b0;
        bus.in_data  = '0;
        bus.op_ready = 1'b0;
        bus.res_val  = 1'b0;
        bus.res_data = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_outs", {bus.op_val, bus.res_ready, bus.out_val, err_timeout}, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_out_data", bus.out_data, 0);
        rstn = 1'b1;
        step();
        chk("rst_rel_count", fifo_count, 0);

        // 1: single transaction, latency and data pass-through
        op_rdy_en     = 1'b1;
        bus.out_ready = 1'b1;
        push_word(32'h0304_0205);
        for (int i = 0; i < 30 && n_out < 1; i++) step();
        step();
        step();
        step();
        chk("t1_op_cnt", n_op, 1);
        chk("t1_op_data", last_op, 32'h0304_0205);
        chk("t1_out_data", last_out, 32'hFFF2_0017);
        chk("t1_latency", out_cyc - op_cyc, 3);
        chk("t1_outv_cycles", n_outv, 1);

        // 2: fill to full with op_ready low
        op_rdy_en    = 1'b0;
        bus.op_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h1020_3040 + 32'(i));
        chk("t2_count_full", fifo_count, 4);
        chk("t2_in_ready_low", bus.in_ready, 1'b0);
        bus.in_val  = 1'b1;
        bus.in_data = 32'h7F80_81FF;
        step();
        step();
        step();
        chk("t2_still_full", fifo_count, 4);
        n0           = n_op;
        op_rdy_en    = 1'b1;
        bus.op_ready = 1'b1;
        for (int i = 0; i < 20 && !bus.in_ready; i++) step();
        chk("t2_pop_first", n_op - n0, 1);
        step();
        bus.in_val = 1'b0;
        drain("t2_drain");
        chk("t2_empty", fifo_count, 0);

        // 3: downstream stall holds DRAIN
        bus.out_ready = 1'b0;
        push_word(32'h0102_0304);
        push_word(32'hFE05_0AF0);
        for (int i = 0; i < 30 && !bus.out_val; i++) step();
        n0 = n_op;
        for (int i = 0; i < 10; i++) begin
            chk("t3_out_val", bus.out_val, 1'b1);
            chk("t3_out_data", bus.out_data, cmul(32'h0102_0304));
            chk("t3_no_op", bus.op_val, 1'b0);
            bus.in_val  = (i == 2);
            bus.in_data = 32'h3355_77AA;
            step();
        end
        bus.in_val = 1'b0;
        chk("t3_no_issue", n_op - n0, 0);
        chk("t3_count", fifo_count, 2);
        bus.out_ready = 1'b1;
        drain("t3_drain");

`ifdef CMPLX_DRV_TIMEOUT_EN
        // 5: watchdog drops the transaction and moves on
        mul_resp = 1'b0;
        push_word(32'h1111_2222);
        push_word(32'h0303_0404);
        for (int i = 0; i < 20 && !bus.res_ready; i++) step();
        v0 = n_outv;
        n0 = 0;
        while (bus.res_ready && n0 < 200) begin
            step();
            n0++;
        end
        chk("t5_wait_len", n0, 64);
        chk("t5_err", err_timeout, 1'b1);
        chk("t5_no_out", n_outv - v0, 0);
        void'(exp_res.pop_front());
        mul_busy = 1'b0;
        for (int i = 0; i < 10 && !bus.op_val; i++) step();
        chk("t5_next_issue", bus.op_val, 1'b1);
        mul_resp = 1'b1;
        drain("t5_drain");
        chk("t5_err_sticky", err_timeout, 1'b1);
`endif

        // 4: software reset while waiting for a result
        mul_resp = 1'b0;
        push_word(32'h0A0B_0C0D);
        push_word(32'h0E0F_1011);
        push_word(32'h1213_1415);
        for (int i = 0; i < 30 && !(bus.res_ready && fifo_count == 2); i++) step();
        chk("t4_pre_count", fifo_count, 2);
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk("t4_res_ready", bus.res_ready, 1'b0);
        chk("t4_count", fifo_count, 0);
        chk("t4_in_ready", bus.in_ready, 1'b1);
        chk("t4_op_val", bus.op_val, 1'b0);
        chk("t4_err", err_timeout, 1'b0);
        exp_op.delete();
        exp_res.delete();
        mul_resp = 1'b1;
        v0 = n_outv;
        for (int i = 0; i < 6; i++) step();
        chk("t4_res_ignored", n_outv - v0, 0);
        chk("t4_idle", {bus.op_val, bus.res_ready}, 0);
        mul_busy = 1'b0;

        // 6: steady push+pop at two entries across pointer wrap
        op_rdy_en    = 1'b0;
        bus.op_ready = 1'b0;
        push_word(32'h6000_0101);
        push_word(32'h6000_0202);
        seq          = 32'h6000_0303;
        op_rdy_en    = 1'b1;
        bus.op_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("t6_count", fifo_count, 2);
            bus.in_val  = bus.op_val;
            bus.in_data = seq;
            step();
            if (bus.in_val) seq = seq + 32'h0000_0101;
        end
        bus.in_val = 1'b0;
        drain("t6_drain");
        chk("t6_empty", fifo_count, 0);
        chk("sb_op_left", exp_op.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
